fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//  Upstream stage of fir_datapath. Collects NB_TAPS coefficients arriving one per
//  handshake on a narrow HWPE-Stream and assembles them into the wide h stream
//  (DATA_WIDTH*NB_TAPS bits) that the datapath reads. Holds the assembled set
//  valid until a reload or clear. Lets h be streamed from memory.
// PARAMETERS
//  DATA_WIDTH  16  width of one coefficient, in bits
//  NB_TAPS     50  number of taps; h width = DATA_WIDTH*NB_TAPS
//  REVERSE     0   0: k-th received coeff -> tap k; 1: k-th received coeff -> tap NB_TAPS-1-k
// PORTS
//  clk_i    in   1                                  clock
//  rst_ni   in   1                                  synchronous active-low reset
//  clear_i  in   1                                  synchronous soft clear
//  ctrl_i   in   fir_coeff_loader_ctrl_t            start (1-cycle pulse)
//  flags_o  out  fir_coeff_loader_flags_t           busy, done (pulse), loaded, count
//  coeff    sink hwpe_stream DATA_WIDTH             input coefficients, one per handshake
//  h        src  hwpe_stream DATA_WIDTH*NB_TAPS     packed taps; tap i at [i*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge):
//   - state IDLE, count=0, all tap registers 0
//   - h.valid=0, coeff.ready=0, flags_o all 0
//   - h.strb='1 at all times
//  FSM: IDLE -> LOAD -> HOLD
//   - IDLE:
//     - coeff.ready=0, h.valid=0
//     - start: go to LOAD, count<=0
//   - LOAD:
//     - coeff.ready=1, h.valid=0, busy=1
//     - each coeff handshake writes coeff.data into the slot indexed by count (REVERSE applied), count++
//     - per byte lane: a lane with strb low keeps its previous tap value
//     - handshake with count==NB_TAPS-1: go to HOLD, count<=0, done=1 for exactly one cycle
//     - h.valid rises on the cycle after the last handshake
//   - HOLD:
//     - h.valid=1 continuously, h.data stable, loaded=1, coeff.ready=0
//     - h.ready is ignored; h is persistent and is not consumed
//     - start: go to LOAD, h.valid drops on the next cycle, old taps overwritten progressively
//  Simultaneous events:
//   - start during LOAD: restart from count=0; an input handshake in that same cycle is discarded
//   - clear_i: same effect as reset, from any state; clear_i wins over start and over a handshake
//   - rst_ni low mid-LOAD: partial set discarded, taps zeroed
//  Counter:
//   - count width $clog2(NB_TAPS), minimum 1
//   - no wrap past NB_TAPS-1
//   - flags_o.count = number of coefficients received in the current load
//  No combinational path from any input to coeff.ready or h.valid; both are derived from state only.
//  Latency: last coeff handshake at cycle t -> h.valid=1 and done=1 at t+1.
// STRUCTURE
//  fir_package gets:
//   - fir_coeff_loader_ctrl_t  { logic start; }
//   - fir_coeff_loader_flags_t { logic busy; logic done; logic loaded; logic [15:0] count; }
//   - state enum fir_coeff_loader_state_t { IDLE, LOAD, HOLD }
//  Single flat module, no sub-module:
//   - FSM
//   - counter
//   - NB_TAPS-entry register array with per-slot write enable, packed by a generate loop
// TESTING (tb_fir_coeff_loader; coeff driven by hwpe_stream_traffic_gen, h checked directly)
//  - reset, start, 50 coeffs 0x0001..0x0032, no stalls -> h.valid at cycle after 50th
//    handshake; tap0=0x0001, tap49=0x0032; done pulses once.
//  - same stream with PROB_STALL=0.3 -> identical h; count tracks handshakes; h.valid=0 until complete.
//  - REVERSE=1, same stream -> tap0=0x0032, tap49=0x0001.
//  - start after 20 coeffs, then 50 coeffs 0x1000.. -> h holds 0x1000..0x1031 only; one done pulse.
//  - clear_i in HOLD -> next cycle h.valid=0, all taps 0; clear_i+start same cycle -> stays IDLE.
//  - HOLD, h.ready toggled randomly 100 cycles -> h.valid stays 1, h.data unchanged;
//    then end-to-end with fir_datapath, RIGHT_SHIFT=17 -> y matches y_gold.txt.

Source files
------------

// File: rtl/fir_coeff_loader_pkg.sv
// Shared types for the FIR coefficient loader.
// Control, status flags and FSM state encoding.
package fir_coeff_loader_pkg;

  typedef struct packed {
    logic start;
  } fir_coeff_loader_ctrl_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        loaded;
    logic [15:0] count;
  } fir_coeff_loader_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } fir_coeff_loader_state_t;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Valid/ready stream with byte strobes.
// Used for both the narrow coeff input and the wide h output.
interface fir_coeff_loader_if #(
  parameter int unsigned DW = 16
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [DW/8-1:0] strb;

  modport master (
    output valid,
    output data,
    output strb,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  strb,
    output ready
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Assembles NB_TAPS narrow coefficients into one wide,
// persistent tap vector for the FIR datapath.
module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NB_TAPS    = 50,
  parameter int unsigned REVERSE    = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  fir_coeff_loader_ctrl_t  ctrl_i,
  output fir_coeff_loader_flags_t flags_o,
  fir_coeff_loader_if.slave       coeff,
  fir_coeff_loader_if.master      h
);

  localparam int unsigned CW =
    (NB_TAPS > 1) ? $clog2(NB_TAPS) : 1;
  localparam int unsigned NL = DATA_WIDTH / 8;
  localparam int unsigned HW = DATA_WIDTH * NB_TAPS;
  localparam logic [CW-1:0] LAST = CW'(NB_TAPS - 1);

  fir_coeff_loader_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;

  logic [DATA_WIDTH-1:0] tap_q [NB_TAPS];
  logic [DATA_WIDTH-1:0] tap_d [NB_TAPS];
  logic [NB_TAPS-1:0]    we;
  logic [CW-1:0]         slot;
  logic                  accept;
  logic [HW-1:0]         h_data;

  // start and clear both discard a handshake in the same cycle
  assign accept = (state_q == LOAD) && coeff.valid
               && !ctrl_i.start && !clear_i;

  assign slot = (REVERSE != 0) ? (LAST - count_q)
                               : count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ctrl_i.start) begin
            state_d = LOAD;
            count_d = '0;
          end
        end
        LOAD: begin
          if (ctrl_i.start) begin
            count_d = '0;
          end else if (accept) begin
            if (count_q == LAST) begin
              state_d = HOLD;
              count_d = '0;
              done_d  = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (ctrl_i.start) begin
            state_d = LOAD;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NB_TAPS; g++) begin : g_tap
    assign we[g] = accept && (slot == CW'(g));
    assign h_data[g*DATA_WIDTH +: DATA_WIDTH] = tap_q[g];
  end

  // lanes with strb low keep their previous byte
  always_comb begin
    for (int i = 0; i < NB_TAPS; i++) begin
      tap_d[i] = clear_i ? '0 : tap_q[i];
      for (int l = 0; l < NL; l++) begin
        if (we[i] && coeff.strb[l]) begin
          tap_d[i][l*8 +: 8] = coeff.data[l*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_TAPS; i++) begin
        tap_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_TAPS; i++) begin
        tap_q[i] <= tap_d[i];
      end
    end
  end

  always_comb begin
    flags_o        = '0;
    flags_o.busy   = (state_q == LOAD);
    flags_o.loaded = (state_q == HOLD);
    flags_o.done   = done_q;
    flags_o.count  = 16'(count_q);
    coeff.ready    = (state_q == LOAD);
    h.valid        = (state_q == HOLD);
    h.strb         = '1;
    h.data         = h_data;
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader, both tap orders,
// checked every cycle against a tap-array reference model.
module tb_fir_coeff_loader;
  import fir_coeff_loader_pkg::*;

  localparam int DW = 16;
  localparam int NT = 50;
  localparam int HW = DW * NT;
  localparam int NL = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic start;
  logic c_valid;
  logic [DW-1:0] c_data;
  logic [NL-1:0] c_strb;
  logic h_ready;

  fir_coeff_loader_ctrl_t  ctrl;
  fir_coeff_loader_flags_t fl0, fl1;

  fir_coeff_loader_if #(.DW(DW)) cif0 ();
  fir_coeff_loader_if #(.DW(DW)) cif1 ();
  fir_coeff_loader_if #(.DW(HW)) hif0 ();
  fir_coeff_loader_if #(.DW(HW)) hif1 ();

  assign ctrl.start  = start;
  assign cif0.valid  = c_valid;
  assign cif0.data   = c_data;
  assign cif0.strb   = c_strb;
  assign cif1.valid  = c_valid;
  assign cif1.data   = c_data;
  assign cif1.strb   = c_strb;
  assign hif0.ready  = h_ready;
  assign hif1.ready  = h_ready;

  fir_coeff_loader #(
    .DATA_WIDTH(DW), .NB_TAPS(NT), .REVERSE(0)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .ctrl_i(ctrl), .flags_o(fl0),
    .coeff(cif0), .h(hif0)
  );

  fir_coeff_loader #(
    .DATA_WIDTH(DW), .NB_TAPS(NT), .REVERSE(1)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .ctrl_i(ctrl), .flags_o(fl1),
    .coeff(cif1), .h(hif1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  // Reference: a loading/holding mode, a received-count,
  // and the tap arrays for each receive order.
  bit m_loading = 1'b0;
  bit m_holding = 1'b0;
  bit m_done    = 1'b0;
  int m_cnt     = 0;
  logic [DW-1:0] m_tap0 [NT];
  logic [DW-1:0] m_tap1 [NT];

  always @(posedge clk) begin
    if (!rst_n || clear) begin
      m_loading = 1'b0;
      m_holding = 1'b0;
      m_done    = 1'b0;
      m_cnt     = 0;
      for (int i = 0; i < NT; i++) begin
        m_tap0[i] = '0;
        m_tap1[i] = '0;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_loading = 1'b1;
        m_holding = 1'b0;
        m_cnt     = 0;
      end else if (m_loading && c_valid) begin
        for (int l = 0; l < NL; l++) begin
          if (c_strb[l]) begin
            m_tap0[m_cnt][l*8 +: 8]      = c_data[l*8 +: 8];
            m_tap1[NT-1-m_cnt][l*8 +: 8] = c_data[l*8 +: 8];
          end
        end
        m_cnt = m_cnt + 1;
        if (m_cnt == NT) begin
          m_cnt     = 0;
          m_loading = 1'b0;
          m_holding = 1'b1;
          m_done    = 1'b1;
        end
      end
    end
  end

  function automatic logic [HW-1:0] model_h(input bit rev);
    logic [HW-1:0] r;
    for (int i = 0; i < NT; i++) begin
      r[i*DW +: DW] = rev ? m_tap1[i] : m_tap0[i];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] tap_of(
    input logic [HW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_h(input string nm,
                       input logic [HW-1:0] act,
                       input logic [HW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      for (int i = 0; i < NT; i++) begin
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
          $display("FAIL %s tap %0d: got %h expected %h",
                   nm, i, act[i*DW +: DW], exp[i*DW +: DW]);
          break;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0_ready",  cif0.ready, m_loading);
      chk("u1_ready",  cif1.ready, m_loading);
      chk("u0_valid",  hif0.valid, m_holding);
      chk("u1_valid",  hif1.valid, m_holding);
      chk("u0_strb",   hif0.strb, {HW/8{1'b1}});
      chk("u0_busy",   fl0.busy, m_loading);
      chk("u1_busy",   fl1.busy, m_loading);
      chk("u0_loaded", fl0.loaded, m_holding);
      chk("u0_done",   fl0.done, m_done);
      chk("u1_done",   fl1.done, m_done);
      chk("u0_count",  fl0.count, 16'(m_cnt));
      chk("u1_count",  fl1.count, 16'(m_cnt));
      chk_h("u0_h", hif0.data, model_h(1'b0));
      chk_h("u1_h", hif1.data, model_h(1'b1));
      if (fl0.done === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit with_valid);
    start   = 1'b1;
    c_valid = with_valid;
    c_data  = 16'hDEAD;
    c_strb  = '1;
    tick();
    start   = 1'b0;
    c_valid = 1'b0;
  endtask

  task automatic send(input int n, input int base,
                      input int stall_pct,
                      input bit rnd_data, input bit rnd_strb);
    int k = 0;
    int guard = 0;
    bit hs;
    while (k < n && guard < 2000) begin
      if (int'($urandom_range(99)) < stall_pct) begin
        c_valid = 1'b0;
      end else begin
        c_valid = 1'b1;
        c_data  = rnd_data ? DW'($urandom) : DW'(base + k);
        c_strb  = rnd_strb ? NL'($urandom) : '1;
      end
      @(negedge clk);
      hs = c_valid && m_loading;
      tick();
      if (hs) k++;
      guard++;
    end
    c_valid = 1'b0;
    if (k < n) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got %0d handshakes expected %0d",
               k, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    int dc;
    rst_n   = 1'b0;
    clear   = 1'b0;
    start   = 1'b0;
    c_valid = 1'b0;
    c_data  = '0;
    c_strb  = '1;
    h_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_h_valid", hif0.valid, 1'b0);
    chk("rst_c_ready", cif0.ready, 1'b0);
    chk("rst_flags",   fl0, '0);
    chk("rst_strb",    hif0.strb, {HW/8{1'b1}});
    rst_n = 1'b1;
    tick();

    // plain ascending load, no stalls
    dc = done_cnt;
    pulse_start(1'b0);
    send(NT, 1, 0, 1'b0, 1'b0);
    chk("lat_valid", hif0.valid, 1'b1);
    chk("lat_done",  fl0.done, 1'b1);
    tick();
    chk("done_low", fl0.done, 1'b0);
    tick();
    chk("s1_done_cnt", done_cnt - dc, 1);
    chk("s1_tap0",   tap_of(hif0.data, 0),  16'h0001);
    chk("s1_tap49",  tap_of(hif0.data, 49), 16'h0032);
    chk("rev_tap0",  tap_of(hif1.data, 0),  16'h0032);
    chk("rev_tap49", tap_of(hif1.data, 49), 16'h0001);

    // same stream, stalled source
    pulse_start(1'b0);
    chk("reload_valid_drop", hif0.valid, 1'b0);
    send(NT, 1, 30, 1'b0, 1'b0);
    tick();
    chk("s2_tap0",  tap_of(hif0.data, 0),  16'h0001);
    chk("s2_tap49", tap_of(hif0.data, 49), 16'h0032);

    // restart mid-load, handshake on the start cycle dropped
    pulse_start(1'b0);
    send(20, 0, 20, 1'b1, 1'b0);
    dc = done_cnt;
    pulse_start(1'b1);
    send(NT, 16'h1000, 10, 1'b0, 1'b0);
    tick();
    chk("s3_done_cnt", done_cnt - dc, 1);
    chk("s3_tap0",   tap_of(hif0.data, 0),  16'h1000);
    chk("s3_tap49",  tap_of(hif0.data, 49), 16'h1031);
    chk("s3_rtap0",  tap_of(hif1.data, 0),  16'h1031);

    // random data and byte strobes
    pulse_start(1'b0);
    send(NT, 0, 20, 1'b1, 1'b1);
    tick();

    // hold is not consumed by h.ready
    for (int i = 0; i < 100; i++) begin
      h_ready = 1'($urandom);
      tick();
    end
    chk("hold_valid", hif0.valid, 1'b1);
    h_ready = 1'b0;

    // clear from HOLD, then clear together with start
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_valid", hif0.valid, 1'b0);
    chk("clr_tap0",  tap_of(hif0.data, 0), 16'h0000);
    chk("clr_tap49", tap_of(hif1.data, 49), 16'h0000);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk("clr_start_busy", fl0.busy, 1'b0);
    chk("clr_start_rdy",  cif0.ready, 1'b0);

    // reset in the middle of a load
    pulse_start(1'b0);
    send(10, 16'h0A00, 0, 1'b0, 1'b0);
    chk("mid_count", fl0.count, 16'd10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_tap0", tap_of(hif0.data, 0), 16'h0000);
    chk("mid_rst_busy", fl0.busy, 1'b0);
    tick();

    // random mix of all controls
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(199) != 0);
      clear   = ($urandom_range(99) < 2);
      start   = ($urandom_range(99) < 3);
      c_valid = ($urandom_range(99) < 75);
      c_data  = DW'($urandom);
      c_strb  = NL'($urandom);
      h_ready = 1'($urandom);
      tick();
    end
    rst_n   = 1'b1;
    clear   = 1'b0;
    start   = 1'b0;
    c_valid = 1'b0;
    tick();
    tick();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
